// File: rtl/seven_seg_scanner.sv
// seven_seg_scanner: six-digit common-anode BCD scanner with frame snapshot, blank gap, hour-zero blanking and colon blink; in clk/reset/en/sec_pulse/6 BCD digits, out an[5:0]/seg[6:0]/dp active-low
module seven_seg_scanner #(
  parameter int DIGIT_CYCLES = 5000,
  parameter int BLANK_CYCLES = 2,
  parameter bit LZB = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       sec_pulse,
  input  logic [3:0] sec_ones,
  input  logic [3:0] sec_tens,
  input  logic [3:0] min_ones,
  input  logic [3:0] min_tens,
  input  logic [3:0] hour_ones,
  input  logic [3:0] hour_tens,
  output logic [5:0] an,
  output logic [6:0] seg,
  output logic       dp
);
  localparam int CW = $clog2(DIGIT_CYCLES);
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0] slot_q, slot_d;
  logic colon_q, colon_d;
  logic [23:0] buf_q, buf_d;
  logic [5:0] an_q, an_d;
  logic [6:0] seg_q, seg_d;
  logic dp_q, dp_d;
  logic [3:0] dig;
  logic snap, last, blank, dark;
  function automatic logic [6:0] dec(input logic [3:0] d);
    case (d)
      4'd0: dec = 7'b1000000;
      4'd1: dec = 7'b1111001;
      4'd2: dec = 7'b0100100;
      4'd3: dec = 7'b0110000;
      4'd4: dec = 7'b0011001;
      4'd5: dec = 7'b0010010;
      4'd6: dec = 7'b0000010;
      4'd7: dec = 7'b1111000;
      4'd8: dec = 7'b0000000;
      4'd9: dec = 7'b0010000;
      default: dec = 7'b0111111;
    endcase
  endfunction
  always_comb begin
    snap = en && slot_q == 3'd0 && cnt_q == '0;
    buf_d = snap ? {hour_tens, hour_ones, min_tens, min_ones, sec_tens, sec_ones} : buf_q;
    last = cnt_q == CW'(DIGIT_CYCLES - 1);
    cnt_d = (!en || last) ? '0 : cnt_q + 1'b1;
    slot_d = !en ? 3'd0 : !last ? slot_q : slot_q == 3'd5 ? 3'd0 : slot_q + 1'b1;
    colon_d = colon_q ^ sec_pulse;
    dig = buf_d[{slot_q, 2'b00} +: 4];
    blank = !en || cnt_q < CW'(BLANK_CYCLES);
    dark = blank || (LZB && slot_q == 3'd5 && dig == 4'd0);
    an_d = dark ? 6'b111111 : ~(6'b000001 << slot_q);
    seg_d = dark ? 7'b1111111 : dec(dig);
    dp_d = (blank || !(slot_q == 3'd2 || slot_q == 3'd4)) ? 1'b1 : ~colon_q;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      slot_q <= 3'd0;
      colon_q <= 1'b0;
      buf_q <= '0;
      an_q <= 6'b111111;
      seg_q <= 7'b1111111;
      dp_q <= 1'b1;
    end else begin
      cnt_q <= cnt_d;
      slot_q <= slot_d;
      colon_q <= colon_d;
      buf_q <= buf_d;
      an_q <= an_d;
      seg_q <= seg_d;
      dp_q <= dp_d;
    end
  end
  assign an = an_q;
  assign seg = seg_q;
  assign dp = dp_q;
endmodule
